// File: rtl/pistorm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pistorm_pkg
// Description : Shared definitions for the Pi-side transaction path: Pi
//               register select codes, bit positions inside the ADDR_HI
//               word, and the queued transaction entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pistorm_pkg;

  // Pi register select codes (PI_A)
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Control bits carried in the ADDR_HI write alongside A23..A16
  localparam int PI_RW_BIT   = 9;
  localparam int PI_BYTE_BIT = 8;

  localparam int TXN_W = 43;

  // One queued bus transaction: {addr[23:0], data[15:0], rw, uds_n, lds_n}
  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } txn_t;

  // Builds the entry pushed by an ADDR_HI write. For byte accesses the
  // address LSB selects the lane: even -> upper strobe, odd -> lower strobe.
  function automatic txn_t build_txn(input logic [15:0] addr_lo,
                                     input logic [15:0] data,
                                     input logic [15:0] hi_word);
    txn_t t;
    logic byte_acc;
    byte_acc = hi_word[PI_BYTE_BIT];
    t.addr   = {hi_word[7:0], addr_lo};
    t.data   = data;
    t.rw     = hi_word[PI_RW_BIT];
    t.uds_n  = byte_acc ?  addr_lo[0] : 1'b0;
    t.lds_n  = byte_acc ? ~addr_lo[0] : 1'b0;
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pi_txn_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pi_txn_fifo
// Description : Generic DEPTH x WIDTH first-word-fall-through FIFO. The head
//               entry is presented combinationally on o_rdata.
// Ports       : clk, rst (async, active high)
//               i_push/i_wdata  - write an entry (ignored when full unless a
//                                 pop happens in the same cycle)
//               i_pop           - retire the head (ignored when empty)
//               o_rdata         - head entry
//               o_level         - current occupancy
//               o_level_nxt     - occupancy after this cycle's push/pop
//               o_full, o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module pi_txn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 43,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [LVL_W-1:0] o_level,
  output logic [LVL_W-1:0] o_level_nxt,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_empty = (level_q == '0);
  assign o_full  = (level_q == LVL_W'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign o_rdata     = mem_q[rd_ptr_q];
  assign o_level     = level_q;
  assign o_level_nxt = level_d;

endmodule
`default_nettype wire

// File: rtl/pi_txn_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pi_txn_queue
// Description : Assembles Pi register writes (DATA, ADDR_LO, ADDR_HI) into
//               68k bus transactions, queues them, hands them to the bus
//               engine via op_valid/op_ready and tracks the in-flight cycle.
// Ports       : PI_CLK, RESET (async, active high)
//               reg_wr_stb/reg_sel/reg_wdata - Pi register write
//               ovf_clr                      - clears sticky overflow
//               op_valid/op_ready/op_*       - head transaction to bus engine
//               op_done/op_rdata             - in-flight cycle completion
//               rd_data, txn_busy, full, overflow, level - Pi-side status
// Revision    : 1.0 - initial release
// ============================================================================
module pi_txn_queue #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             PI_CLK,
  input  logic             RESET,
  input  logic             reg_wr_stb,
  input  logic [1:0]       reg_sel,
  input  logic [15:0]      reg_wdata,
  input  logic             ovf_clr,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [23:0]      op_addr,
  output logic [15:0]      op_data,
  output logic             op_rw,
  output logic             op_uds_n,
  output logic             op_lds_n,
  input  logic             op_done,
  input  logic [15:0]      op_rdata,
  output logic [15:0]      rd_data,
  output logic             txn_busy,
  output logic             full,
  output logic             overflow,
  output logic [LVL_W-1:0] level
);

  import pistorm_pkg::*;

  logic [15:0]      data_stg_q,    data_stg_d;
  logic [15:0]      addr_lo_stg_q, addr_lo_stg_d;
  logic             inflight_q,    inflight_d;
  logic             inflight_rw_q, inflight_rw_d;
  logic             overflow_q,    overflow_d;
  logic             txn_busy_q,    txn_busy_d;
  logic [15:0]      rd_data_q,     rd_data_d;

  logic             push_req;
  logic             pop;
  logic             done;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [LVL_W-1:0] fifo_level_nxt;
  logic [TXN_W-1:0] wr_bits;
  logic [TXN_W-1:0] head_bits;
  txn_t             wr_entry;
  txn_t             head;

  assign push_req = reg_wr_stb && (reg_sel == REG_ADDR_HI);
  assign wr_entry = build_txn(addr_lo_stg_q, data_stg_q, reg_wdata);
  assign wr_bits  = wr_entry;
  assign head     = head_bits;

  // op_ready without a valid head is a no-op; op_done only counts while a
  // cycle is actually outstanding.
  assign pop  = op_ready && op_valid;
  assign done = op_done && inflight_q;

  pi_txn_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TXN_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk         (PI_CLK),
    .rst         (RESET),
    .i_push      (push_req),
    .i_wdata     (wr_bits),
    .i_pop       (pop),
    .o_rdata     (head_bits),
    .o_level     (fifo_level),
    .o_level_nxt (fifo_level_nxt),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  always_comb begin
    data_stg_d    = data_stg_q;
    addr_lo_stg_d = addr_lo_stg_q;
    inflight_d    = inflight_q;
    inflight_rw_d = inflight_rw_q;
    overflow_d    = overflow_q;
    rd_data_d     = rd_data_q;

    if (reg_wr_stb && (reg_sel == REG_DATA)) begin
      data_stg_d = reg_wdata;
    end
    if (reg_wr_stb && (reg_sel == REG_ADDR_LO)) begin
      addr_lo_stg_d = reg_wdata;
    end

    // The direction of the completing cycle was captured when it was popped,
    // since the FIFO head has already moved on.
    if (done && inflight_rw_q) begin
      rd_data_d = op_rdata;
    end

    // A new pop in the completion cycle keeps the engine busy.
    if (pop) begin
      inflight_d    = 1'b1;
      inflight_rw_d = head.rw;
    end else if (done) begin
      inflight_d = 1'b0;
    end

    // Set has priority over clear so a dropped push is never lost.
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (push_req && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end

    txn_busy_d = (fifo_level_nxt != '0) || inflight_d;
  end

  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      data_stg_q    <= '0;
      addr_lo_stg_q <= '0;
      inflight_q    <= 1'b0;
      inflight_rw_q <= 1'b0;
      overflow_q    <= 1'b0;
      txn_busy_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      data_stg_q    <= data_stg_d;
      addr_lo_stg_q <= addr_lo_stg_d;
      inflight_q    <= inflight_d;
      inflight_rw_q <= inflight_rw_d;
      overflow_q    <= overflow_d;
      txn_busy_q    <= txn_busy_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign op_valid = !fifo_empty;
  assign op_addr  = head.addr;
  assign op_data  = head.data;
  assign op_rw    = head.rw;
  assign op_uds_n = head.uds_n;
  assign op_lds_n = head.lds_n;
  assign rd_data  = rd_data_q;
  assign txn_busy = txn_busy_q;
  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign level    = fifo_level;

endmodule
`default_nettype wire

// File: tb/tb_pi_txn_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pi_txn_queue
// Description : Self-checking bench for pi_txn_queue: directed vector table,
//               hand-written corner sequences and randomized traffic checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_txn_queue;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             PI_CLK = 1'b0;
  logic             RESET  = 1'b1;
  logic             reg_wr_stb = 1'b0;
  logic [1:0]       reg_sel = 2'd0;
  logic [15:0]      reg_wdata = 16'h0;
  logic             ovf_clr = 1'b0;
  logic             op_valid;
  logic             op_ready = 1'b0;
  logic [23:0]      op_addr;
  logic [15:0]      op_data;
  logic             op_rw;
  logic             op_uds_n;
  logic             op_lds_n;
  logic             op_done = 1'b0;
  logic [15:0]      op_rdata = 16'h0;
  logic [15:0]      rd_data;
  logic             txn_busy;
  logic             full;
  logic             overflow;
  logic [LVL_W-1:0] level;

  pi_txn_queue #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .PI_CLK(PI_CLK), .RESET(RESET), .reg_wr_stb(reg_wr_stb), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .ovf_clr(ovf_clr), .op_valid(op_valid),
    .op_ready(op_ready), .op_addr(op_addr), .op_data(op_data), .op_rw(op_rw),
    .op_uds_n(op_uds_n), .op_lds_n(op_lds_n), .op_done(op_done),
    .op_rdata(op_rdata), .rd_data(rd_data), .txn_busy(txn_busy), .full(full),
    .overflow(overflow), .level(level)
  );

  initial forever #5 PI_CLK = ~PI_CLK;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } m_txn_t;

  m_txn_t      mq[$];
  logic [15:0] m_dstg, m_lostg, m_rd;
  logic        m_inflight, m_inflight_rw, m_ovf;

  task automatic model_reset();
    mq.delete();
    m_dstg = 0; m_lostg = 0; m_rd = 0;
    m_inflight = 0; m_inflight_rw = 0; m_ovf = 0;
  endtask

  // Applies one clock of the current inputs to the model.
  task automatic model_step();
    m_txn_t h;
    m_txn_t t;
    bit     is_byte;
    bit     pop_now;
    bit     done_now;
    pop_now  = op_ready && (mq.size() != 0);
    done_now = op_done && m_inflight;
    if (done_now && m_inflight_rw) m_rd = op_rdata;
    if (pop_now) begin
      h = mq.pop_front();
      m_inflight = 1;
      m_inflight_rw = h.rw;
    end else if (done_now) begin
      m_inflight = 0;
    end
    if (ovf_clr) m_ovf = 0;
    if (reg_wr_stb) begin
      case (reg_sel)
        2'd0: m_dstg = reg_wdata;
        2'd1: m_lostg = reg_wdata;
        2'd2: begin
          is_byte = reg_wdata[8];
          t.addr  = {reg_wdata[7:0], m_lostg};
          t.data  = m_dstg;
          t.rw    = reg_wdata[9];
          // byte access: even address uses the upper lane, odd the lower
          t.uds_n = is_byte && (m_lostg[0] == 1'b1);
          t.lds_n = is_byte && (m_lostg[0] == 1'b0);
          if (mq.size() < DEPTH) mq.push_back(t);
          else m_ovf = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".op_valid"}, op_valid, mq.size() != 0);
    check({tag, ".level"}, level, mq.size());
    check({tag, ".full"}, full, mq.size() == DEPTH);
    check({tag, ".overflow"}, overflow, m_ovf);
    check({tag, ".rd_data"}, rd_data, m_rd);
    check({tag, ".txn_busy"}, txn_busy, (mq.size() != 0) || m_inflight);
    if (mq.size() != 0) begin
      check({tag, ".op_addr"}, op_addr, mq[0].addr);
      check({tag, ".op_data"}, op_data, mq[0].data);
      check({tag, ".op_rw"}, op_rw, mq[0].rw);
      check({tag, ".op_uds_n"}, op_uds_n, mq[0].uds_n);
      check({tag, ".op_lds_n"}, op_lds_n, mq[0].lds_n);
    end
  endtask

  // Called at a falling edge: drive, clock, update model, compare.
  task automatic cycle(input string tag, input logic wr, input logic [1:0] sel,
                       input logic [15:0] wd, input logic clr, input logic rdy,
                       input logic dn, input logic [15:0] rdat);
    reg_wr_stb = wr; reg_sel = sel; reg_wdata = wd; ovf_clr = clr;
    op_ready = rdy; op_done = dn; op_rdata = rdat;
    @(posedge PI_CLK);
    model_step();
    @(negedge PI_CLK);
    check_all(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [15:0] wd;
    logic        rdy;
    logic        dn;
    logic [15:0] rdat;
    logic        e_valid;
    logic [23:0] e_addr;
    logic [15:0] e_data;
    logic        e_rw;
    logic        e_uds;
    logic        e_lds;
    logic [15:0] e_rd;
    logic        e_busy;
    logic [2:0]  e_level;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 2'd0, 16'hBEEF, 1'b0, 1'b0, 16'h0,    1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 2'd1, 16'h1234, 1'b0, 1'b0, 16'h0,    1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 2'd2, 16'h0012, 1'b0, 1'b0, 16'h0,    1'b1, 24'h121234, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd1};
    tbl[3] = '{1'b0, 2'd0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0};
    tbl[4] = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b1, 16'h5555, 1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};
    tbl[5] = '{1'b1, 2'd1, 16'h0001, 1'b0, 1'b0, 16'h0,    1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};
    tbl[6] = '{1'b1, 2'd2, 16'h0300, 1'b0, 1'b0, 16'h0,    1'b1, 24'h000001, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1};
    tbl[7] = '{1'b0, 2'd0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0};
    tbl[8] = '{1'b0, 2'd0, 16'h0,    1'b0, 1'b1, 16'h00A5, 1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h00A5, 1'b0, 3'd0};
    tbl[9] = '{1'b1, 2'd0, 16'h0000, 1'b1, 1'b1, 16'h1111, 1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h00A5, 1'b0, 3'd0};

    model_reset();
    repeat (2) @(negedge PI_CLK);
    RESET = 1'b0;
    check_all("reset");

    for (int i = 0; i < 10; i++) begin
      reg_wr_stb = tbl[i].wr; reg_sel = tbl[i].sel; reg_wdata = tbl[i].wd;
      ovf_clr = 1'b0; op_ready = tbl[i].rdy; op_done = tbl[i].dn; op_rdata = tbl[i].rdat;
      @(posedge PI_CLK);
      model_step();
      @(negedge PI_CLK);
      check($sformatf("vec%0d.op_valid", i), op_valid, tbl[i].e_valid);
      check($sformatf("vec%0d.level", i), level, tbl[i].e_level);
      check($sformatf("vec%0d.txn_busy", i), txn_busy, tbl[i].e_busy);
      check($sformatf("vec%0d.rd_data", i), rd_data, tbl[i].e_rd);
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d.op_addr", i), op_addr, tbl[i].e_addr);
        check($sformatf("vec%0d.op_data", i), op_data, tbl[i].e_data);
        check($sformatf("vec%0d.op_rw", i), op_rw, tbl[i].e_rw);
        check($sformatf("vec%0d.op_uds_n", i), op_uds_n, tbl[i].e_uds);
        check($sformatf("vec%0d.op_lds_n", i), op_lds_n, tbl[i].e_lds);
      end
    end

    // ---- full boundary, overflow, set-beats-clear, ordering ----
    cycle("fill.data", 1, 2'd0, 16'h1000, 0, 0, 0, 16'h0);
    cycle("fill.lo",   1, 2'd1, 16'h2000, 0, 0, 0, 16'h0);
    for (int k = 1; k <= 5; k++)
      cycle("fill.push", 1, 2'd2, 16'(k), 0, 0, 0, 16'h0);
    check("full.level", level, 4);
    check("full.flag", full, 1);
    check("full.overflow", overflow, 1);
    cycle("ovf.clr", 0, 2'd0, 16'h0, 1, 0, 0, 16'h0);
    check("ovf.cleared", overflow, 0);
    cycle("full.pushpop", 1, 2'd2, 16'h0006, 0, 1, 0, 16'h0);
    check("pushpop.level", level, 4);
    check("pushpop.overflow", overflow, 0);
    cycle("ovf.setwins", 1, 2'd2, 16'h0007, 1, 0, 0, 16'h0);
    check("setwins.overflow", overflow, 1);
    cycle("ovf.clr2", 0, 2'd0, 16'h0, 1, 0, 0, 16'h0);
    // done coincident with ready on the next head: busy must never drop
    for (int k = 0; k < 3; k++) begin
      cycle("drain", 0, 2'd0, 16'h0, 0, 1, 1, 16'h0);
      check("drain.busy", txn_busy, 1);
    end
    check("order.last_head", op_addr, 24'h062000);
    cycle("drain.last", 0, 2'd0, 16'h0, 0, 1, 1, 16'h0);
    check("drain.last_busy", txn_busy, 1);
    cycle("drain.done", 0, 2'd0, 16'h0, 0, 0, 1, 16'h0);
    check("drain.idle_busy", txn_busy, 0);

    // ---- empty boundary: push and ready together while empty ----
    cycle("empty.pushrdy", 1, 2'd2, 16'h0042, 0, 1, 0, 16'h0);
    check("empty.level", level, 1);
    cycle("empty.pop", 0, 2'd0, 16'h0, 0, 1, 0, 16'h0);
    cycle("empty.done", 0, 2'd0, 16'h0, 0, 0, 1, 16'h0);

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      cycle("rand", ($urandom % 3) == 0, 2'($urandom), 16'($urandom),
            ($urandom % 16) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
            16'($urandom));
    end

    // ---- reset mid-transaction ----
    for (int n = 0; n < 12; n++)
      cycle("pre.drain", 0, 2'd0, 16'h0, 1, 1, 1, 16'h0);
    cycle("pre.lo",  1, 2'd1, 16'h0010, 0, 0, 0, 16'h0);
    cycle("pre.rd",  1, 2'd2, 16'h0200, 0, 0, 0, 16'h0);
    cycle("pre.pop", 0, 2'd0, 16'h0, 0, 1, 0, 16'h0);
    cycle("pre.done", 0, 2'd0, 16'h0, 0, 0, 1, 16'h3C3C);
    for (int k = 0; k < 4; k++)
      cycle("pre.push", 1, 2'd2, 16'h0011 + 16'(k), 0, 0, 0, 16'h0);
    cycle("pre.inflight", 0, 2'd0, 16'h0, 0, 1, 0, 16'h0);
    check("pre.level", level, 3);
    check("pre.busy", txn_busy, 1);
    check("pre.rd_data", rd_data, 16'h3C3C);
    reg_wr_stb = 0; op_ready = 0; op_done = 0; ovf_clr = 0;
    #2;
    RESET = 1'b1;
    #1;
    check("arst.op_valid", op_valid, 0);
    check("arst.level", level, 0);
    check("arst.txn_busy", txn_busy, 0);
    check("arst.rd_data", rd_data, 0);
    model_reset();
    @(negedge PI_CLK);
    RESET = 1'b0;
    cycle("post.idle", 0, 2'd0, 16'h0, 0, 1, 1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pi_txn_queue.md
Name: pi_txn_queue

Overview:
- Sits between the Pi GPIO register interface and the 68k bus-cycle state machine in the CPLD.
- Assembles Pi register writes (ADDR_LO, DATA, ADDR_HI) into complete bus transactions and queues them in a small FIFO.
- Presents queued transactions to the bus engine through a valid/ready handshake, and returns read data and busy/overflow status to the Pi side.
- Lets the Pi post several writes back-to-back without polling between them.

Parameters:
- DEPTH, 4, number of queued transactions; power of two, minimum 2.
- LVL_W, $clog2(DEPTH+1), width of the level output.

Ports:
- PI_CLK  in  1  200 MHz Pi-side clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- reg_wr_stb  in  1  single-cycle pulse: PI_WR rising edge, already synchronised.
- reg_sel  in  2  register select (PI_A): 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS.
- reg_wdata  in  16  PI_D value captured with reg_wr_stb.
- ovf_clr  in  1  pulse that clears the sticky overflow flag.
- op_valid  out  1  the queue head is a valid transaction.
- op_ready  in  1  pulse from the bus engine: head accepted (bus cycle S1).
- op_addr  out  24  head address A23..A0.
- op_data  out  16  head write data.
- op_rw  out  1  head direction: 1 = read.
- op_uds_n  out  1  head upper data strobe, active low.
- op_lds_n  out  1  head lower data strobe, active low.
- op_done  in  1  pulse from the bus engine: in-flight cycle finished (S7).
- op_rdata  in  16  read data from the bus, valid with op_done.
- rd_data  out  16  data from the most recent completed read.
- txn_busy  out  1  high while a transaction is queued or in flight.
- full  out  1  queue holds DEPTH entries.
- overflow  out  1  sticky flag: a push was dropped.
- level  out  LVL_W  current number of queued entries.

Behaviour:
- Reset (asynchronous): all pointers 0, level 0, staging registers 0, inflight 0, overflow 0, rd_data 0. All op_* outputs read from an empty queue with op_valid = 0.
- Staging registers:
  - reg_wr_stb with DATA: data_stg <= reg_wdata.
  - reg_wr_stb with ADDR_LO: addr_lo_stg <= reg_wdata.
  - reg_wr_stb with STATUS: no effect in this block.
- Push on reg_wr_stb with ADDR_HI. Entry fields:
  - addr = {reg_wdata[7:0], addr_lo_stg}
  - data = data_stg
  - rw = reg_wdata[9]
  - byte = reg_wdata[8]
  - uds_n = byte ? addr_lo_stg[0] : 0
  - lds_n = byte ? ~addr_lo_stg[0] : 0
- FIFO is first-word fall-through. op_* outputs are driven combinationally from mem[rd_ptr].
- op_valid = (level != 0).
- Latency: a push in cycle N gives op_valid = 1 in cycle N+1 when the queue was empty.
- Pop on op_ready && op_valid: rd_ptr advances and inflight <= 1.
  - op_ready while op_valid = 0 is ignored.
- On op_done && inflight: inflight <= 0; if the completed op_rw was 1, rd_data <= op_rdata.
  - op_done while inflight = 0 is ignored.
- Same cycle op_done and op_ready: the new pop wins; inflight stays 1; rd_data still updates.
- Completed direction comes from an inflight_rw register loaded at pop.
- txn_busy = (level != 0) || inflight. It is registered: updates in the cycle after the causing event.
- Full boundary:
  - Push while full with no pop in the same cycle: entry dropped, level unchanged, overflow <= 1.
  - Push and pop in the same cycle while full: both happen, level stays DEPTH.
- Empty boundary: push and op_ready in the same cycle while empty: push only, because op_valid was 0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. level tracks occupancy separately; full = (level == DEPTH).
- Overflow priority: if ovf_clr and a new overflow occur in the same cycle, set wins.
- Ordering: transactions complete strictly in push order. Reads behind writes are permitted. rd_data always reflects the last read to complete.
- Reset mid-transaction: the queue and inflight are discarded immediately. The bus engine must be reset by the same RESET.

Decomposition:
- Shared package pistorm_pkg holds:
  - REG_DATA, REG_ADDR_LO, REG_ADDR_HI, REG_STATUS constants.
  - Transaction entry layout: {addr[23:0], data[15:0], rw, uds_n, lds_n}, width 43.
  - Bit positions PI_RW_BIT = 9 and PI_BYTE_BIT = 8.
- One sub-module, pi_txn_fifo: a generic DEPTH x 43-bit first-word-fall-through FIFO with push, pop, level, full and empty. Staging, inflight tracking and status logic stay in the top.

Test Plan:
- Word write: DATA=0xBEEF, ADDR_LO=0x1234, ADDR_HI=0x0012 → next cycle op_valid=1, op_addr=0x121234, op_data=0xBEEF, op_rw=0, op_uds_n=0, op_lds_n=0.
- Byte read at odd address: ADDR_LO=0x0001, ADDR_HI=0x0300 → op_rw=1, uds_n=1, lds_n=0. Then op_ready, then op_done with op_rdata=0x00A5 → rd_data=0x00A5, txn_busy falls one cycle later.
- Fill 4 writes with no op_ready, then a 5th ADDR_HI → full=1, level=4, overflow=1, 5th entry absent. ovf_clr → overflow=0.
- At full, ADDR_HI coincident with op_ready → level stays 4, no overflow, the new entry pops last in order.
- op_done coincident with op_ready on the next head → inflight stays 1, txn_busy never drops.
- RESET asserted with 3 entries queued and one in flight → op_valid=0, level=0, txn_busy=0 and rd_data=0 immediately, without waiting for a clock edge.
